// File: rtl/score_bcd_scan_pkg.sv
// ---------------------------------------------------------------------------
// ddr_pkg -- shared definitions for the score / anode-scan block.
//   state_t      : BCD adder FSM states (IDLE, ADD, COMMIT)
//   NUM_DIGITS   : number of BCD digits held in the score
//   BCD_W        : width of one BCD digit
//   BCD_MAX      : largest legal BCD digit; larger hit values clamp to it
//   AN_RST       : anode pattern after reset (units digit selected)
//   clamp_bcd()  : min(v, BCD_MAX)
// ---------------------------------------------------------------------------
package ddr_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ADD    = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam int          NUM_DIGITS = 4;
  localparam int          BCD_W      = 4;
  localparam logic [3:0]  BCD_MAX    = 4'd9;
  localparam logic [3:0]  AN_RST     = 4'b1110;

  function automatic logic [3:0] clamp_bcd(input logic [3:0] v);
    return (v > BCD_MAX) ? BCD_MAX : v;
  endfunction

endpackage

// File: rtl/score_bcd_scan_if.sv
// ---------------------------------------------------------------------------
// score_bcd_scan_if -- hit request handshake plus the display-side outputs.
//   master : drives clear, hit_valid, hit_points; observes everything else
//   slave  : the score block; drives hit_ready, the four BCD digits,
//            saturated and the active-low anode select AN
// ---------------------------------------------------------------------------
interface score_bcd_scan_if;
  import ddr_pkg::*;

  logic             clear;
  logic             hit_valid;
  logic [BCD_W-1:0] hit_points;
  logic             hit_ready;
  logic [BCD_W-1:0] one;
  logic [BCD_W-1:0] ten;
  logic [BCD_W-1:0] hundred;
  logic [BCD_W-1:0] thousand;
  logic             saturated;
  logic [3:0]       AN;

  modport master (
    output clear, hit_valid, hit_points,
    input  hit_ready, one, ten, hundred, thousand, saturated, AN
  );

  modport slave (
    input  clear, hit_valid, hit_points,
    output hit_ready, one, ten, hundred, thousand, saturated, AN
  );

endinterface

// File: rtl/score_bcd_scan_anode_scan.sv
// ---------------------------------------------------------------------------
// anode_scan -- free-running digit scanner.
//   clk, rst : clock, asynchronous active-high reset
//   AN       : registered active-low one-hot anode select; steps
//              1110 -> 1101 -> 1011 -> 0111 -> 1110 every SCAN_DIV clocks
// Parameter SCAN_DIV (2..2^20): clocks per anode step.
// ---------------------------------------------------------------------------
module anode_scan
  import ddr_pkg::*;
#(
  parameter int SCAN_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] AN
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sel_q, sel_d;
  logic [3:0]       an_q, an_d;
  logic             tick;

  always_comb begin
    tick  = (cnt_q == CNT_LAST);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
    sel_d = tick ? sel_q + 2'd1 : sel_q;
    // Derived from the next select so AN and sel move on the same edge.
    an_d  = ~(4'b0001 << sel_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      sel_q <= 2'd0;
      an_q  <= AN_RST;
    end else begin
      cnt_q <= cnt_d;
      sel_q <= sel_d;
      an_q  <= an_d;
    end
  end

  assign AN = an_q;

endmodule

// File: rtl/score_bcd_scan.sv
// ---------------------------------------------------------------------------
// score_bcd_scan -- 4-digit BCD game score with a serial BCD adder and the
// anode scan for the seven-segment decoder.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of score_bcd_scan_if
//              clear      synchronous score clear (beats any hit)
//              hit_valid / hit_points / hit_ready : add request handshake
//              one..thousand : registered BCD digits, all update together
//              saturated  : sticky overflow flag (score forced to 9999)
//              AN         : active-low one-hot digit select
// A hit takes 6 cycles: accept in IDLE, four ADD cycles (one digit each,
// units first), then COMMIT copies the shadow into the visible digits.
// ---------------------------------------------------------------------------
module score_bcd_scan
  import ddr_pkg::*;
#(
  parameter int SCAN_DIV        = 100000,
  parameter int SCORE_MAX_DIGIT = 9
) (
  input  logic               clk,
  input  logic               rst,
  score_bcd_scan_if.slave    bus
);

  localparam logic [BCD_W-1:0] SAT_DIGIT = BCD_W'(SCORE_MAX_DIGIT);

  state_t           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [BCD_W-1:0] addend_q, addend_d;
  logic             sat_q, sat_d;
  logic [BCD_W-1:0] shadow_q [NUM_DIGITS];
  logic [BCD_W-1:0] shadow_d [NUM_DIGITS];
  logic [BCD_W-1:0] digits_q [NUM_DIGITS];
  logic [BCD_W-1:0] digits_d [NUM_DIGITS];
  logic [BCD_W:0]   sum;
  logic             accept;

  // clear in the same cycle as a request wins: the hit is not taken.
  assign accept = (state_q == IDLE) && bus.hit_valid && !bus.clear;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    addend_d = addend_q;
    sat_d    = sat_q;
    shadow_d = shadow_q;
    digits_d = digits_q;

    // Only the units digit receives the addend; higher digits just ripple.
    sum = {1'b0, shadow_q[idx_q]}
        + ((idx_q == 2'd0) ? {1'b0, addend_q} : 5'd0)
        + {4'd0, carry_q};

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          addend_d = clamp_bcd(bus.hit_points);
          shadow_d = digits_q;
          carry_d  = 1'b0;
          idx_d    = 2'd0;
          state_d  = ADD;
        end
      end
      ADD: begin
        if (sum > 5'd9) begin
          shadow_d[idx_q] = BCD_W'(sum - 5'd10);
          carry_d         = 1'b1;
        end else begin
          shadow_d[idx_q] = sum[BCD_W-1:0];
          carry_d         = 1'b0;
        end
        if (idx_q == 2'd3) begin
          state_d = COMMIT;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      COMMIT: begin
        // Carry out of the thousands digit means the score overflowed.
        if (carry_q) begin
          for (int i = 0; i < NUM_DIGITS; i++) digits_d[i] = SAT_DIGIT;
          sat_d = 1'b1;
        end else begin
          digits_d = shadow_q;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // clear discards any add in flight; the scanner is not touched.
    if (bus.clear) begin
      for (int i = 0; i < NUM_DIGITS; i++) digits_d[i] = '0;
      sat_d   = 1'b0;
      carry_d = 1'b0;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= 2'd0;
      carry_q  <= 1'b0;
      addend_q <= '0;
      sat_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      addend_q <= addend_d;
      sat_q    <= sat_d;
    end
  end

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        shadow_q[gi] <= '0;
        digits_q[gi] <= '0;
      end else begin
        shadow_q[gi] <= shadow_d[gi];
        digits_q[gi] <= digits_d[gi];
      end
    end
  end

  assign bus.hit_ready = (state_q == IDLE);
  assign bus.one       = digits_q[0];
  assign bus.ten       = digits_q[1];
  assign bus.hundred   = digits_q[2];
  assign bus.thousand  = digits_q[3];
  assign bus.saturated = sat_q;

  anode_scan #(
    .SCAN_DIV (SCAN_DIV)
  ) u_anode_scan (
    .clk (clk),
    .rst (rst),
    .AN  (bus.AN)
  );

endmodule
